// File: rtl/fir_decim_param.sv
// Pipelined decimating FIR: product, pairwise-sum and round/saturate stages,
// with runtime-writable coefficients and an ENABLE-gated valid pipe.
module fir_decim_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 15,
    parameter int ADDR_W = 4,
    parameter int FRAC   = 15,
    parameter int DECIM  = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENABLE,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic                     coef_we,
    input  logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] output_data,
    output logic                     out_valid,
    output logic                     sat_flag,
    output logic signed [DATA_W-1:0] sampleT
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int PS_W   = PROD_W + 1;
    localparam int NPS    = (TAPS + 1) / 2;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int SUM_W  = ACC_W + 1;
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RSH    = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic        [ADDR_W:0]  TAPS_LIM = (ADDR_W + 1)'(TAPS);
    localparam logic signed [SUM_W-1:0] RND      = (FRAC > 0) ? (SUM_W'(1) <<< RSH) : '0;
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] taps [TAPS];
    logic signed [PROD_W-1:0] prod [TAPS];
    logic signed [PS_W-1:0]   psum [NPS];
    logic        [PH_W-1:0]   phase;
    logic                     last_phase;
    logic                     v0, v1, v2;
    logic                     out_valid_r, sat_r;

    logic signed [ACC_W-1:0]  acc;
    logic signed [SUM_W-1:0]  rounded, shifted;
    logic                     sat_hi, sat_lo;
    logic signed [DATA_W-1:0] sat_data;

    assign last_phase = (phase == PH_W'(DECIM - 1));

    // NOTE: the coefficient store is a small register file, not a RAM, so it
    // is cleared by reset like every other register here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_we && ({1'b0, coef_addr} < TAPS_LIM)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every stage
    // samples the previous stage's value from before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
            sampleT <= '0;
            phase   <= '0;
            v0      <= 1'b0;
        end else if (ENABLE) begin
            // emit tag: this accept is the one that wraps the phase counter
            v0 <= in_valid & last_phase;
            if (in_valid) begin
                taps[0] <= input_data;
                for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
                sampleT <= input_data;
                phase   <= last_phase ? '0 : phase + PH_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) prod[i] <= '0;
            v1 <= 1'b0;
        end else if (ENABLE) begin
            for (int i = 0; i < TAPS; i++) prod[i] <= PROD_W'(taps[i]) * PROD_W'(coef[i]);
            v1 <= v0;
        end
    end

    for (genvar j = 0; j < NPS; j++) begin : g_psum
        if (2 * j + 1 < TAPS) begin : g_pair
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)         psum[j] <= '0;
                else if (ENABLE) psum[j] <= PS_W'(prod[2*j]) + PS_W'(prod[2*j+1]);
            end
        end else begin : g_pass
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)         psum[j] <= '0;
                else if (ENABLE) psum[j] <= PS_W'(prod[2*j]);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         v2 <= 1'b0;
        else if (ENABLE) v2 <= v1;
    end

    // NOTE: every always_comb output is assigned a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        acc = '0;
        for (int j = 0; j < NPS; j++) acc = acc + ACC_W'(psum[j]);
        rounded  = SUM_W'(acc) + RND;
        shifted  = rounded >>> FRAC;
        sat_hi   = (shifted > SAT_MAX);
        sat_lo   = (shifted < SAT_MIN);
        sat_data = shifted[DATA_W-1:0];
        if (sat_hi)      sat_data = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sat_lo) sat_data = {1'b1, {(DATA_W-1){1'b0}}};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            output_data <= '0;
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else if (ENABLE) begin
            out_valid_r <= v2;
            sat_r       <= v2 & (sat_hi | sat_lo);
            if (v2) output_data <= sat_data;
        end
    end

    // A pulse held across an ENABLE-low stretch is shown once, on resume.
    assign out_valid = out_valid_r & ENABLE;
    assign sat_flag  = sat_r & ENABLE;

endmodule

// File: tb/tb_fir_decim_param.sv
// Directed bench for fir_decim_param: a DECIM=1 and a DECIM=4 instance share
// stimulus; a behavioural model feeds per-instance expectation queues.
module tb_fir_decim_param;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        int          en;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE, in_valid, coef_we;
    logic [15:0] input_data, coef_data;
    logic [3:0]  coef_addr;

    logic [15:0] out1, st1, out4, st4;
    logic        outv1, sat1, outv4, sat4;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int pulses1 = 0;
    int pulses4 = 0;

    logic signed [15:0] m_taps [15];
    logic signed [15:0] m_coef [15];
    int                 m_phase = 0;
    exp_t               q1[$];
    exp_t               q4[$];

    fir_decim_param #(.DECIM(1)) dut1 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .in_valid(in_valid),
        .input_data(input_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .output_data(out1), .out_valid(outv1),
        .sat_flag(sat1), .sampleT(st1)
    );

    fir_decim_param #(.DECIM(4)) dut4 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .in_valid(in_valid),
        .input_data(input_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .output_data(out4), .out_valid(outv4),
        .sat_flag(sat4), .sampleT(st4)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        longint acc = 0;
        longint r;
        for (int i = 0; i < 15; i++) acc += longint'(m_taps[i]) * longint'(m_coef[i]);
        r = (acc + 16384) >>> 15;
        e.en = 0;
        if (r > 32767) begin
            e.data = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.data = 16'h8000; e.sat = 1'b1;
        end else begin
            e.data = r[15:0];  e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic cyc(input logic en, input logic iv, input logic [15:0] d,
                       input logic we, input logic [3:0] a, input logic [15:0] cd);
        exp_t e;
        ENABLE = en; in_valid = iv; input_data = d;
        coef_we = we; coef_addr = a; coef_data = cd;
        @(posedge CLK);
        if (we && a < 4'd15) m_coef[a] = cd;
        if (en) begin
            en_cnt++;
            if (iv) begin
                for (int i = 14; i > 0; i--) m_taps[i] = m_taps[i-1];
                m_taps[0] = d;
                e    = model();
                e.en = en_cnt;
                q1.push_back(e);
                m_phase = (m_phase == 3) ? 0 : m_phase + 1;
                if (m_phase == 0) q4.push_back(e);
            end
        end
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        cyc(1'b1, 1'b1, d, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, a, d);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out1"}, out1, 0);
        check({tag, "_v1"},   outv1, 0);
        check({tag, "_sat1"}, sat1, 0);
        check({tag, "_st1"},  st1, 0);
        check({tag, "_out4"}, out4, 0);
        check({tag, "_v4"},   outv4, 0);
        check({tag, "_st4"},  st4, 0);
    endtask

    // Async reset asserted mid-cycle; model and scoreboard start over.
    task automatic mid_reset();
        #3 RST = 1'b1;
        #1 check_zero_outputs("rst_async");
        q1.delete();
        q4.delete();
        for (int i = 0; i < 15; i++) begin
            m_taps[i] = '0;
            m_coef[i] = '0;
        end
        m_phase = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (!ENABLE) begin
                check("gated_v1", outv1, 0);
                check("gated_v4", outv4, 0);
            end
            check("sat_noval1", sat1 & ~outv1, 0);
            check("sat_noval4", sat4 & ~outv4, 0);
            if (outv1) begin
                pulses1++;
                if (q1.size() == 0) check("unexpected_v1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("data1", out1, e.data);
                    check("sat1", sat1, e.sat);
                    check("lat1", en_cnt, e.en + 3);
                end
            end
            if (outv4) begin
                pulses4++;
                if (q4.size() == 0) check("unexpected_v4", 1, 0);
                else begin
                    e = q4.pop_front();
                    check("data4", out4, e.data);
                    check("sat4", sat4, e.sat);
                    check("lat4", en_cnt, e.en + 3);
                end
            end
        end
    end

    initial begin
        logic [15:0] hold_o1, hold_s1, hold_o4, hold_s4;
        int          p1, p4;

        for (int i = 0; i < 15; i++) begin
            m_taps[i] = '0;
            m_coef[i] = '0;
        end
        RST = 1'b1; ENABLE = 1'b0; in_valid = 1'b0; input_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        #12 check_zero_outputs("rst_init");
        @(posedge CLK);
        #1 RST = 1'b0;

        // Impulse through coef[0]=0.5, coef[1]=0.25
        wr(4'd0, 16'h4000);
        wr(4'd1, 16'h2000);
        push(16'h1000);
        check("sampleT", st1, 16'h1000);
        push(16'h0000);
        push(16'h0000);
        push(16'h0000);
        check("imp_v0", outv1, 1);
        check("imp_d0", out1, 16'h0800);
        push(16'h0000);
        check("imp_d1", out1, 16'h0400);
        push(16'h0000);
        check("imp_d2", out1, 16'h0000);
        idle(4);

        // Saturation, both polarities
        for (int i = 0; i < 15; i++) wr(4'(i), 16'h7FFF);
        for (int i = 0; i < 15; i++) push(16'h7FFF);
        idle(3);
        check("satp_v", outv1, 1);
        check("satp_d", out1, 16'h7FFF);
        check("satp_f", sat1, 1);
        for (int i = 0; i < 15; i++) push(16'h8000);
        idle(3);
        check("satn_d", out1, 16'h8000);
        check("satn_f", sat1, 1);

        // Reset with the pipe full, then no pulses for 3 enabled cycles
        for (int i = 0; i < 5; i++) push(16'($urandom));
        mid_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("post_rst_v1", outv1, 0);
            check("post_rst_v4", outv4, 0);
        end

        // Decimation by 4 over 16 samples
        wr(4'd0, 16'h4000);
        wr(4'd2, 16'hC000);
        wr(4'd3, 16'h1234);
        p1 = pulses1;
        p4 = pulses4;
        for (int i = 0; i < 16; i++) push(16'($urandom));
        idle(4);
        check("dec_pulses4", pulses4 - p4, 4);
        check("dec_pulses1", pulses1 - p1, 16);

        // Input gaps, then an ENABLE-low freeze, then resume
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 4'd0, 16'h0);
        hold_o1 = out1; hold_s1 = st1; hold_o4 = out4; hold_s4 = st4;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 16'($urandom), 1'b0, 4'd0, 16'h0);
            check("frz_out1", out1, hold_o1);
            check("frz_st1", st1, hold_s1);
            check("frz_out4", out4, hold_o4);
            check("frz_st4", st4, hold_s4);
        end
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 4'd0, 16'h0);
        idle(4);

        // Live coefficient update while streaming a constant
        mid_reset();
        wr(4'd0, 16'h4000);
        for (int i = 0; i < 6; i++) push(16'h1000);
        check("live_pre", out1, 16'h0800);
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 4'd0, 16'h2000);
        push(16'h1000);
        push(16'h1000);
        check("live_w2", out1, 16'h0800);
        push(16'h1000);
        check("live_w3_v", outv1, 1);
        check("live_w3", out1, 16'h0400);
        cyc(1'b1, 1'b1, 16'h1000, 1'b1, 4'd15, 16'h7FFF);
        for (int i = 0; i < 4; i++) push(16'h1000);
        check("addr15_ign", out1, 16'h0400);
        idle(4);

        check("drain_q1", q1.size(), 0);
        check("drain_q4", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decim_param.md
Name: fir_decim_param

Overview:
Parametrised, pipelined, decimating FIR filter. It is the successor to the fixed 15-tap Q1.15 comb filter in the sigma-delta filter chain.
Adds runtime-writable coefficients, a valid handshake, integer decimation, round-half-up, and saturation with an overflow indicator.
Sits after the modulator/CIC stage and feeds the downstream sample consumer.

Parameters:
DATA_W, 16, input/output sample width, signed two's complement
COEF_W, 16, coefficient width, signed
TAPS, 15, number of taps (>=2)
ADDR_W, 4, coefficient address width; must satisfy 2^ADDR_W >= TAPS
FRAC, 15, right-shift applied to the accumulator (coefficient fractional bits)
DECIM, 1, decimation factor (>=1); one output per DECIM accepted samples

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous reset, active-high
ENABLE  in  1  pipeline advance; when low, all data/valid/phase state holds
in_valid  in  1  input_data is valid this cycle
input_data  in  DATA_W  input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  coefficient index (0 = newest-sample tap)
coef_data  in  COEF_W  coefficient value
output_data  out  DATA_W  filtered, decimated sample
out_valid  out  1  one-cycle pulse: output_data is new
sat_flag  out  1  pulse with out_valid when that output was clipped
sampleT  out  DATA_W  debug: last accepted input sample

Behaviour:
- Reset (async, RST=1): delay line, product and partial-sum registers, valid pipe, phase counter, and all coefficients go to 0. output_data=0, out_valid=0, sat_flag=0, sampleT=0. Reset mid-stream discards all in-flight samples.
- Accept: a sample is accepted on an edge where ENABLE=1 and in_valid=1.
  - Delay line shifts: tap0 <= input_data.
  - sampleT <= input_data.
  - Phase counter increments, wrapping DECIM-1 -> 0.
- ENABLE=1, in_valid=0: delay line and phase counter hold; a bubble (valid=0) enters the pipe.
- ENABLE=0: every register except the coefficient store holds, including the valid pipe. out_valid is forced to 0 during any cycle in which ENABLE=0.
- Output generation: a sample whose acceptance left the phase counter at 0 (i.e. it was the DECIM-th since the last wrap) is tagged "emit". Only emit-tagged samples produce out_valid. With DECIM=1 every accepted sample emits.
- Pipeline, counting ENABLE=1 edges after accept edge k:
  - edge k+1: register TAPS products, each DATA_W+COEF_W bits.
  - edge k+2: register pairwise partial sums (odd TAPS passes the last product through).
  - edge k+3: final sum, rounding, and saturation; output_data/out_valid/sat_flag registered.
  - Latency is therefore 3 enabled cycles.
- Arithmetic:
  - Accumulator width = DATA_W+COEF_W+ceil(log2(TAPS)); no internal overflow.
  - Result = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift).
  - If the result is outside the DATA_W signed range, clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1) and assert sat_flag.
- Output holding: output_data holds its last value between pulses. out_valid and sat_flag are 0 except on emit cycles.
- Coefficient writes:
  - On an edge with coef_we=1 and coef_addr<TAPS: coef[coef_addr] <= coef_data. Writes are independent of ENABLE.
  - coef_addr>=TAPS: write ignored.
  - A written coefficient is used by the product stage from the next edge onward. Samples already past the product stage are unaffected.
- Simultaneous write and accept in the same cycle is legal. The new coefficient applies to products formed on the following edge.

Test Plan:
1. Reset: assert RST asynchronously mid-cycle with pipe full -> all outputs 0 immediately; no out_valid for 3 enabled cycles after release.
2. Impulse, DECIM=1: coef[0]=0x4000, coef[1]=0x2000, others 0; input 0x1000 then zeros -> out_valid pulses carry 0x0800, then 0x0400, then 0x0000. The first pulse occurs 3 cycles after the impulse is accepted.
3. Saturation: all coefs 0x7FFF, 15 samples of 0x7FFF -> output 0x7FFF with sat_flag=1. Repeat with 0x8000 input -> output 0x8000, sat_flag=1.
4. Decimation, DECIM=4: 16 consecutive accepted samples -> exactly 4 out_valid pulses, for the 4th, 8th, 12th, and 16th samples, each 3 cycles after its acceptance.
5. Flow control:
   - in_valid gaps -> no extra out_valid; results match the gap-free reference model.
   - ENABLE low for 5 cycles mid-stream -> state frozen, out_valid=0 throughout; stream resumes with identical values.
6. Live coefficient update: while streaming constant 0x1000 with coef[0]=0x4000, write coef[0]=0x2000 -> outputs step from 0x0800 to 0x0400, with the step landing exactly 3 cycles after the write edge (next product edge plus 2 pipeline stages). A write to addr 15 changes nothing.
